serial_sub_ctrl: RTL and testbench

Bit-serial multi-bit subtractor controller. It computes diff = a - b over WIDTH clock cycles, one bit per cycle LSB-first, reusing a single 1-bit subtractor cell (two half-subtractor stages plus a borrow register). It is the sequencing layer above the combinational half-subtractor datapath. Callers use a start/done handshake.

---
 rtl/sub_ctrl_pkg.sv | 12 +
 rtl/sub_bit_cell.sv | 22 ++
 rtl/serial_sub_ctrl.sv | 87 ++++++++
 tb/tb_serial_sub_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_ctrl_pkg.sv
// Shared state encoding and default width for the bit-serial subtractor controller.
package sub_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor built from two cascaded half-subtractor stages.
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic d1;
    logic b1;
    logic b2;

    always_comb begin
        d1   = x ^ y;
        b1   = ~x & y;
        d    = d1 ^ bin;
        b2   = ~d1 & bin;
        bout = b1 | b2;
    end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: diff = a - b, one bit per cycle LSB-first through a
// single sub_bit_cell, with a start/done handshake.
module serial_sub_ctrl
    import sub_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             borrow_reg;
    logic             cell_d;
    logic             cell_bout;

    sub_bit_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // The result word fills from the top, so after WIDTH shifts bit 0 holds the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            cnt        <= '0;
            borrow_reg <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr       <= a;
                        b_sr       <= b;
                        res_sr     <= '0;
                        cnt        <= '0;
                        borrow_reg <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sr       <= a_sr >> 1;
                    b_sr       <= b_sr >> 1;
                    res_sr     <= {cell_d, res_sr[WIDTH-1:1]};
                    borrow_reg <= cell_bout;
                    cnt        <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff       <= {cell_d, res_sr[WIDTH-1:1]};
                        borrow_out <= cell_bout;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed, table-driven bench for serial_sub_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_sub_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       borrow2;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
    } vec_t;

    vec_t vecs[6];

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    serial_sub_ctrl #(.WIDTH(2)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .a          (a2),
        .b          (b2),
        .busy       (busy2),
        .done       (done2),
        .diff       (diff2),
        .borrow_out (borrow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one WIDTH=8 operation; scrambles operands right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                                 output int lat, output int busy_cycles, output logic wide_done);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = av ^ bv;
        lat = -1;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cycles++;
        end
        @(negedge clk);
        wide_done = done;
    endtask

    initial begin
        int   lat;
        int   bcyc;
        logic wide;
        int   cyc;
        int   ndone;
        int   seen;

        tests_run = 0;
        tests_failed = 0;
        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        vecs[5] = '{8'h01, 8'hFF, 8'h02, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        start2 = 1'b0;
        a2 = '0;
        b2 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {22'd0, busy, done, diff, borrow_out}, 32'd0);
        checkOutput("reset_outputs_w2", {27'd0, busy2, done2, diff2, borrow2}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat, bcyc, wide);
            checkOutput($sformatf("vec%0d_latency", i), lat, 8);
            checkOutput($sformatf("vec%0d_busy_cycles", i), bcyc, 8);
            checkOutput($sformatf("vec%0d_diff", i), {24'd0, diff}, {24'd0, vecs[i].exp_diff});
            checkOutput($sformatf("vec%0d_borrow", i), {31'd0, borrow_out}, {31'd0, vecs[i].exp_borrow});
            checkOutput($sformatf("vec%0d_done_width", i), {31'd0, wide}, 32'd0);
        end

        // Back-to-back with start held high; operands disturbed mid-RUN then restored.
        @(negedge clk);
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        cyc = 0;
        ndone = 0;
        for (int k = 0; k < 60 && ndone < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (done) begin
                ndone++;
                if (ndone > 1) checkOutput($sformatf("held_interval%0d", ndone), cyc, 10);
                checkOutput($sformatf("held_diff%0d", ndone), {24'd0, diff}, 32'h0000_00F0);
                checkOutput($sformatf("held_borrow%0d", ndone), {31'd0, borrow_out}, 32'd1);
                cyc = 0;
            end else if (ndone > 0 && cyc == 4) begin
                a = 8'hFF;
                b = 8'h00;
            end else if (ndone > 0 && cyc == 7) begin
                a = 8'h10;
                b = 8'h20;
            end
        end
        start = 1'b0;
        checkOutput("held_done_count", ndone, 4);
        repeat (2) @(negedge clk);

        // Reset during the fourth RUN cycle discards the operation.
        start = 1'b1;
        a = 8'h80;
        b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_outputs", {22'd0, busy, done, diff, borrow_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checkOutput("no_activity_after_reset", seen, 0);
        applyStimulus(8'h80, 8'h01, lat, bcyc, wide);
        checkOutput("post_reset_latency", lat, 8);
        checkOutput("post_reset_diff", {24'd0, diff}, 32'h0000_007F);
        checkOutput("post_reset_borrow", {31'd0, borrow_out}, 32'd0);

        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checkOutput($sformatf("idle_hold%0d", k), {22'd0, busy, done, diff, borrow_out},
                        {22'd0, 1'b0, 1'b0, 8'h7F, 1'b0});
        end

        // Exhaustive WIDTH=2 sweep.
        for (int i = 0; i < 16; i++) begin
            logic [1:0] av;
            logic [1:0] bv;
            av = 2'(i >> 2);
            bv = 2'(i);
            @(negedge clk);
            start2 = 1'b1;
            a2 = av;
            b2 = bv;
            @(posedge clk);
            @(negedge clk);
            start2 = 1'b0;
            lat = -1;
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (done2) begin
                    lat = k;
                    break;
                end
            end
            checkOutput($sformatf("w2_%0d_%0d_latency", av, bv), lat, 2);
            checkOutput($sformatf("w2_%0d_%0d_diff", av, bv), {30'd0, diff2}, {30'd0, 2'(av - bv)});
            checkOutput($sformatf("w2_%0d_%0d_borrow", av, bv), {31'd0, borrow2}, {31'd0, (av < bv)});
            @(negedge clk);
            checkOutput($sformatf("w2_%0d_%0d_done_width", av, bv), {31'd0, done2}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
